// File: rtl/sssp_rd_resp_gen.sv
// SSSP read-response generator: forwards worker read bursts to tile memory and
// expands each returned R beat into a response task carrying the burst's context.

package sssp_rd_resp_pkg;
    typedef struct packed {
        logic [31:0] ts;
        logic [31:0] locale;
    } task_t;

    typedef logic [3:0]  subtype_t;
    typedef logic [5:0]  cq_slice_slot_t;
    typedef logic [63:0] data_t;
    typedef logic [7:0]  byte_t;

    typedef struct packed {
        task_t          tsk;
        subtype_t       subtype;
        logic           mark_last;
        cq_slice_slot_t cq_slot;
        byte_t          arlen;
    } ctx_t;
endpackage

module sssp_rd_resp_gen
    import sssp_rd_resp_pkg::*;
#(
    parameter int TILE_ID   = 0,
    parameter int CTX_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    input  logic [31:0]                  s_araddr,
    input  logic [2:0]                   s_arsize,
    input  logic [7:0]                   s_arlen,
    input  task_t                        s_task,
    input  subtype_t                     s_subtype,
    input  logic                         s_mark_last,
    input  cq_slice_slot_t               s_cq_slot,
    output logic                         m_arvalid,
    input  logic                         m_arready,
    output logic [31:0]                  m_araddr,
    output logic [2:0]                   m_arsize,
    output logic [7:0]                   m_arlen,
    input  logic                         m_rvalid,
    output logic                         m_rready,
    input  logic [63:0]                  m_rdata,
    input  logic                         m_rlast,
    output logic                         out_valid,
    input  logic                         out_ready,
    output task_t                        out_task,
    output data_t                        out_data,
    output byte_t                        out_word_id,
    output subtype_t                     out_subtype,
    output cq_slice_slot_t               out_cq_slot,
    output logic                         out_last,
    output logic                         err_sticky,
    output logic [$clog2(CTX_DEPTH):0]   outstanding
);
    localparam int PTR_W = $clog2(CTX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ctx_t                ctx_mem_q [CTX_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    byte_t               beat_cnt_q, beat_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    task_t               out_task_q, out_task_d;
    data_t               out_data_q, out_data_d;
    byte_t               out_word_id_q, out_word_id_d;
    subtype_t            out_subtype_q, out_subtype_d;
    cq_slice_slot_t      out_cq_slot_q, out_cq_slot_d;
    logic                out_last_q, out_last_d;

    ctx_t                head;
    ctx_t                push_ctx;
    logic                ctx_full, ctx_nonempty, push, r_hs, final_beat, pop;

    assign head     = ctx_mem_q[rd_ptr_q];
    assign m_araddr = s_araddr;
    assign m_arsize = s_arsize;
    assign m_arlen  = s_arlen;

    always_comb begin
        // Full is decoded from the registered count, so a pop this cycle cannot admit a push.
        ctx_full     = (count_q == CNT_W'(CTX_DEPTH));
        ctx_nonempty = (count_q != '0);
        s_arready    = m_arready & ~ctx_full;
        m_arvalid    = s_arvalid & ~ctx_full;
        push         = s_arvalid & s_arready;
        push_ctx     = '{tsk: s_task, subtype: s_subtype, mark_last: s_mark_last,
                         cq_slot: s_cq_slot, arlen: s_arlen};
        m_rready     = ctx_nonempty & (~out_valid_q | out_ready);
        r_hs         = m_rvalid & m_rready;
        final_beat   = (beat_cnt_q == head.arlen);
        pop          = r_hs & final_beat;

        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        beat_cnt_d    = beat_cnt_q;
        err_d         = err_q;
        out_valid_d   = out_valid_q & ~out_ready;
        out_task_d    = out_task_q;
        out_data_d    = out_data_q;
        out_word_id_d = out_word_id_q;
        out_subtype_d = out_subtype_q;
        out_cq_slot_d = out_cq_slot_q;
        out_last_d    = out_last_q;

        if (r_hs) begin
            out_valid_d   = 1'b1;
            out_task_d    = head.tsk;
            out_data_d    = m_rdata;
            out_word_id_d = beat_cnt_q;
            out_subtype_d = head.subtype;
            out_cq_slot_d = head.cq_slot;
            out_last_d    = head.mark_last & final_beat;
            // The beat count alone decides the burst end; rlast is only audited.
            beat_cnt_d    = final_beat ? '0 : beat_cnt_q + 8'd1;
            if (m_rlast != final_beat) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ctx_mem_q[wr_ptr_q] <= push_ctx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        out_task_q    <= out_task_d;
        out_data_q    <= out_data_d;
        out_word_id_q <= out_word_id_d;
        out_subtype_q <= out_subtype_d;
        out_cq_slot_q <= out_cq_slot_d;
        out_last_q    <= out_last_d;
    end

    assign out_valid   = out_valid_q;
    assign out_task    = out_task_q;
    assign out_data    = out_data_q;
    assign out_word_id = out_word_id_q;
    assign out_subtype = out_subtype_q;
    assign out_cq_slot = out_cq_slot_q;
    assign out_last    = out_last_q;
    assign err_sticky  = err_q;
    assign outstanding = count_q;

`ifdef XILINX_SIMULATOR
    logic [31:0] sim_cycle_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sim_cycle_q <= '0;
        end else begin
            sim_cycle_q <= sim_cycle_q + 32'd1;
            if (out_valid_q && out_ready) begin
                $display("[%0d] tile %0d rd_resp slot=%0d ts=%0h locale=%0h word_id=%0d last=%0b",
                         sim_cycle_q, TILE_ID, out_cq_slot_q, out_task_q.ts,
                         out_task_q.locale, out_word_id_q, out_last_q);
            end
        end
    end
`endif
endmodule

// File: tb/tb_sssp_rd_resp_gen.sv
// Bench for sssp_rd_resp_gen: burst-level reference model checked every cycle,
// plus directed scenarios with literal expectations.

module tb_sssp_rd_resp_gen;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_araddr = '0;
    logic [2:0]  s_arsize = '0;
    logic [7:0]  s_arlen = '0;
    logic [63:0] s_task = '0;
    logic [3:0]  s_subtype = '0;
    logic        s_mark_last = 1'b0;
    logic [5:0]  s_cq_slot = '0;
    logic        m_arvalid;
    logic        m_arready = 1'b1;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize;
    logic [7:0]  m_arlen;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [63:0] m_rdata = '0;
    logic        m_rlast = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_task;
    logic [63:0] out_data;
    logic [7:0]  out_word_id;
    logic [3:0]  out_subtype;
    logic [5:0]  out_cq_slot;
    logic        out_last;
    logic        err_sticky;
    logic [2:0]  outstanding;

    always #5 clk = ~clk;

    sssp_rd_resp_gen #(.TILE_ID(0), .CTX_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arsize(s_arsize), .s_arlen(s_arlen), .s_task(s_task),
        .s_subtype(s_subtype), .s_mark_last(s_mark_last), .s_cq_slot(s_cq_slot),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arsize(m_arsize), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task),
        .out_data(out_data), .out_word_id(out_word_id), .out_subtype(out_subtype),
        .out_cq_slot(out_cq_slot), .out_last(out_last),
        .err_sticky(err_sticky), .outstanding(outstanding)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Downstream ready: directed value or random per cycle.
    logic ready_cmd = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_bit = 1'b1;
    assign out_ready = rand_ready ? rnd_bit : ready_cmd;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] tsk;
        logic [3:0]  sub;
        logic        mark;
        logic [5:0]  slot;
        int          len;
    } burst_t;

    typedef struct {
        logic [63:0] tsk;
        logic [63:0] data;
        logic [7:0]  wid;
        logic [3:0]  sub;
        logic [5:0]  slot;
        logic        last;
    } resp_t;

    burst_t bq[$];
    resp_t  eq[$];
    int     m_beat = 0;
    bit     m_err = 1'b0;
    bit     mon_en = 1'b0;
    int     out_hs_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_rr;
            chk("s_arready", 64'(s_arready), 64'(m_arready && bq.size() < DEPTH));
            chk("m_arvalid", 64'(m_arvalid), 64'(s_arvalid && bq.size() < DEPTH));
            chk("ar_forward", {21'd0, m_araddr, m_arsize, m_arlen}, {21'd0, s_araddr, s_arsize, s_arlen});
            chk("outstanding", 64'(outstanding), 64'(bq.size()));
            chk("err_sticky", 64'(err_sticky), 64'(m_err));
            chk("out_valid", 64'(out_valid), 64'(eq.size() != 0));
            exp_rr = (bq.size() != 0) && (eq.size() == 0 || out_ready);
            chk("m_rready", 64'(m_rready), 64'(exp_rr));
            if (out_valid && eq.size() != 0) begin
                chk("out_task", out_task, eq[0].tsk);
                chk("out_data", out_data, eq[0].data);
                chk("out_word_id", 64'(out_word_id), 64'(eq[0].wid));
                chk("out_subtype", 64'(out_subtype), 64'(eq[0].sub));
                chk("out_cq_slot", 64'(out_cq_slot), 64'(eq[0].slot));
                chk("out_last", 64'(out_last), 64'(eq[0].last));
                if (out_ready) begin
                    void'(eq.pop_front());
                    out_hs_cnt++;
                end
            end
            if (!rstn) begin
                bq.delete();
                eq.delete();
                m_beat = 0;
                m_err  = 1'b0;
            end else begin
                if (m_rvalid && m_rready && bq.size() != 0) begin
                    resp_t r;
                    bit    fin;
                    fin    = (m_beat == bq[0].len);
                    r.tsk  = bq[0].tsk;
                    r.data = m_rdata;
                    r.wid  = 8'(m_beat);
                    r.sub  = bq[0].sub;
                    r.slot = bq[0].slot;
                    r.last = bq[0].mark && fin;
                    eq.push_back(r);
                    if (m_rlast != fin) m_err = 1'b1;
                    if (fin) begin
                        void'(bq.pop_front());
                        m_beat = 0;
                    end else begin
                        m_beat++;
                    end
                end
                if (s_arvalid && s_arready)
                    bq.push_back('{s_task, s_subtype, s_mark_last, s_cq_slot, int'(s_arlen)});
            end
        end
    end

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] addr;
        int          len;
    } mb_t;

    mb_t mq[$];
    int  mem_beat = 0;
    bit  mem_en = 1'b0;
    bit  stray = 1'b0;
    int  corrupt_beat = -1;

    always begin
        bit          hs, arhs, rst;
        logic [31:0] a;
        logic [7:0]  l;
        @(negedge clk);
        hs   = m_rvalid && m_rready;
        arhs = m_arvalid && m_arready;
        rst  = !rstn;
        a    = m_araddr;
        l    = m_arlen;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            mem_beat = 0;
        end else begin
            if (hs && mq.size() != 0) begin
                if (mem_beat == mq[0].len) begin
                    void'(mq.pop_front());
                    mem_beat = 0;
                end else begin
                    mem_beat++;
                end
            end
            if (arhs) mq.push_back('{a, int'(l)});
        end
        if (mq.size() != 0) begin
            m_rvalid = mem_en;
            m_rdata  = {mq[0].addr, 24'h0, 8'(mem_beat)} ^ 64'h7;
            m_rlast  = (mem_beat == mq[0].len) ^ (mem_beat == corrupt_beat);
        end else begin
            m_rvalid = stray;
            m_rdata  = '0;
            m_rlast  = 1'b0;
        end
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ar(input logic [31:0] addr, input logic [7:0] len, input bit mark,
                          input logic [5:0] slot, input logic [63:0] tsk, input logic [3:0] sub);
        s_araddr    = addr;
        s_arlen     = len;
        s_arsize    = 3'd3;
        s_mark_last = mark;
        s_cq_slot   = slot;
        s_task      = tsk;
        s_subtype   = sub;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input bit mark,
                           input logic [5:0] slot, input logic [63:0] tsk, input logic [3:0] sub);
        int n = 0;
        set_ar(addr, len, mark, slot, tsk, sub);
        s_arvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_arready && n < 200);
        if (!s_arready) timeout_fail("ar_accept");
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
    endtask

    task automatic wait_rhs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_rvalid && m_rready) && n < 200);
        if (!(m_rvalid && m_rready)) timeout_fail("r_handshake");
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bq.size() == 0 && eq.size() == 0 && mq.size() == 0) && n < 3000);
        if (n >= 3000) timeout_fail("idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          n;
        logic [63:0] snap_data;
        logic [7:0]  snap_wid;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err_sticky), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Stray R beat with no context: never accepted, no error
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_m_rready", 64'(m_rready), 64'd0);
        end
        chk("stray_err", 64'(err_sticky), 64'd0);
        @(posedge clk);
        #1;
        stray  = 1'b0;
        mem_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single-beat burst, one-cycle latency, data pass-through
        send_ar(32'd5, 8'd0, 1'b1, 6'd1, 64'h1111_0000_2222_0001, 4'h2);
        wait_rhs();
        chk("t1_valid_before", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_valid_after", 64'(out_valid), 64'd1);
        chk("t1_data", out_data, 64'h0000_0005_0000_0007);
        chk("t1_word_id", 64'(out_word_id), 64'd0);
        chk("t1_last", 64'(out_last), 64'd1);
        wait_idle();

        // 2: four back-to-back beats, outstanding 1 -> 0 after the fourth
        base = out_hs_cnt;
        send_ar(32'h100, 8'd3, 1'b1, 6'd2, 64'hAAAA_0001_BBBB_0002, 4'h3);
        for (int k = 0; k < 4; k++) begin
            wait_rhs();
            chk("t2_outstanding_busy", 64'(outstanding), 64'd1);
        end
        @(negedge clk);
        chk("t2_outstanding_done", 64'(outstanding), 64'd0);
        wait_idle();
        chk("t2_task_count", 64'(out_hs_cnt - base), 64'd4);

        // 3: context FIFO full, fifth AR stalls until a burst retires
        mem_en    = 1'b0;
        m_arready = 1'b0;
        set_ar(32'h180, 8'd1, 1'b0, 6'd3, 64'h0, 4'h1);
        s_arvalid = 1'b1;
        @(negedge clk);
        chk("t3_arready_blocked", 64'(s_arready), 64'd0);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++)
            send_ar(32'h400 + 32'(k * 16), 8'd1, 1'(k & 1), 6'(10 + k),
                    {32'(k), 32'hC0DE_0000 + 32'(k)}, 4'(k));
        set_ar(32'h500, 8'd1, 1'b1, 6'd20, 64'h5555_0000_5555_0005, 4'h5);
        s_arvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_fifth_stalled", 64'(s_arready), 64'd0);
            chk("t3_outstanding_full", 64'(outstanding), 64'd4);
        end
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        wait_rhs();
        wait_rhs();
        chk("t3_full_with_pop", 64'(s_arready), 64'd0);
        @(negedge clk);
        chk("t3_fifth_accepted", 64'(s_arready), 64'd1);
        chk("t3_outstanding_after_pop", 64'(outstanding), 64'd3);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        wait_idle();

        // 4: downstream stall mid-burst
        base = out_hs_cnt;
        send_ar(32'h200, 8'd7, 1'b1, 6'd4, 64'h4444_0004_4444_0004, 4'h4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_word_id == 8'd2) && n < 100);
        if (n >= 100) timeout_fail("t4_reach_beat2");
        @(posedge clk);
        #1;
        ready_cmd = 1'b0;
        @(negedge clk);
        snap_data = out_data;
        snap_wid  = out_word_id;
        repeat (10) begin
            @(negedge clk);
            chk("t4_m_rready_stalled", 64'(m_rready), 64'd0);
            chk("t4_data_stable", out_data, snap_data);
            chk("t4_wid_stable", 64'(out_word_id), 64'(snap_wid));
        end
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        wait_idle();
        chk("t4_task_count", 64'(out_hs_cnt - base), 64'd8);

        // 5: early rlast flags an error but the count still drives the pop
        base = out_hs_cnt;
        chk("t5_err_before", 64'(err_sticky), 64'd0);
        corrupt_beat = 1;
        send_ar(32'h300, 8'd2, 1'b1, 6'd5, 64'h5000_0005_6000_0006, 4'h6);
        wait_idle();
        corrupt_beat = -1;
        chk("t5_err_set", 64'(err_sticky), 64'd1);
        chk("t5_outstanding", 64'(outstanding), 64'd0);
        chk("t5_task_count", 64'(out_hs_cnt - base), 64'd3);

        // 6: 256-beat burst under random backpressure, then reset mid-burst
        rand_ready = 1'b1;
        base = out_hs_cnt;
        send_ar(32'h600, 8'd255, 1'b1, 6'd6, 64'h6666_0006_7777_0007, 4'h7);
        wait_idle();
        chk("t6_task_count", 64'(out_hs_cnt - base), 64'd256);

        send_ar(32'h700, 8'd255, 1'b1, 6'd7, 64'h7777_0007_8888_0008, 4'h8);
        for (int k = 0; k < 100; k++) wait_rhs();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_outstanding", 64'(outstanding), 64'd0);
        chk("t6_rst_err", 64'(err_sticky), 64'd0);
        @(posedge clk);
        #1;
        rstn       = 1'b1;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = out_hs_cnt;
        send_ar(32'h800, 8'd1, 1'b1, 6'd8, 64'h8888_0008_9999_0009, 4'h9);
        wait_idle();
        chk("t6_recover_count", 64'(out_hs_cnt - base), 64'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
